// File: rtl/serial_link_sched.sv
// Sequencer for a shared half-duplex serial link. It runs a down phase of host frames, waits for
// the receiver to acknowledge, turns the line around, then runs the receiver's up phase.
module serial_link_sched #(
   parameter int unsigned DnFrameBits = 21,
   parameter int unsigned DnFrames    = 8,
   parameter int unsigned DnGap       = 1,
   parameter int unsigned UpFrameBits = 13,
   parameter int unsigned UpFrames    = 18,
   parameter int unsigned UpGap       = 1,
   parameter int unsigned Turn        = 2,
   parameter int unsigned Timeout     = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic       abort_i,
   input  logic       rx_done_i,
   output logic       updown_o,
   output logic       sen_n_o,
   output logic [4:0] bit_cnt_o,
   output logic [4:0] frame_cnt_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o
);

   localparam logic [4:0] DnLastBit   = 5'(DnFrameBits - 1);
   localparam logic [4:0] DnLastFrame = 5'(DnFrames - 1);
   localparam logic [4:0] UpLastBit   = 5'(UpFrameBits - 1);
   localparam logic [4:0] UpLastFrame = 5'(UpFrames - 1);
   localparam logic [7:0] DnGapLast   = 8'(DnGap - 1);
   localparam logic [7:0] UpGapLast   = 8'(UpGap - 1);
   localparam logic [7:0] TurnLast    = 8'(Turn - 1);
   localparam logic [7:0] TimeoutLast = 8'(Timeout - 1);

   typedef enum logic [3:0] {
      StIdle,
      StDown,
      StDgap,
      StWaitAck,
      StTurna,
      StUp,
      StUgap,
      StFin,
      StErr
   } state_e;

   state_e     state_q;
   logic       updown_q;
   logic       sen_n_q;
   logic [4:0] bit_q;
   logic [4:0] frame_q;
   logic [7:0] timer_q;
   logic       busy_q;
   logic       done_q;
   logic       error_q;

   // Outputs are registered alongside the state, so each branch sets the values that belong to
   // the state being entered. The shared timer serves gaps, turnaround and the ack timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         updown_q <= 1'b0;
         sen_n_q  <= 1'b1;
         bit_q    <= 5'd0;
         frame_q  <= 5'd0;
         timer_q  <= 8'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort_i) begin
            state_q  <= StIdle;
            updown_q <= 1'b0;
            sen_n_q  <= 1'b1;
            bit_q    <= 5'd0;
            frame_q  <= 5'd0;
            timer_q  <= 8'd0;
            busy_q   <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle, StErr: begin
                  if (start_i) begin
                     state_q  <= StDown;
                     updown_q <= 1'b0;
                     sen_n_q  <= 1'b0;
                     bit_q    <= 5'd0;
                     frame_q  <= 5'd0;
                     timer_q  <= 8'd0;
                     busy_q   <= 1'b1;
                     error_q  <= 1'b0;
                  end
               end

               StDown: begin
                  if (bit_q == DnLastBit) begin
                     bit_q   <= 5'd0;
                     sen_n_q <= 1'b1;
                     timer_q <= 8'd0;
                     state_q <= (frame_q == DnLastFrame) ? StWaitAck : StDgap;
                  end else begin
                     bit_q <= bit_q + 5'd1;
                  end
               end

               StDgap: begin
                  if (timer_q == DnGapLast) begin
                     state_q <= StDown;
                     sen_n_q <= 1'b0;
                     frame_q <= frame_q + 5'd1;
                     timer_q <= 8'd0;
                  end else begin
                     timer_q <= timer_q + 8'd1;
                  end
               end

               StWaitAck: begin
                  // A late ack on the final timer cycle still wins over the timeout.
                  if (rx_done_i) begin
                     state_q  <= StTurna;
                     updown_q <= 1'b1;
                     timer_q  <= 8'd0;
                  end else if (timer_q == TimeoutLast) begin
                     state_q <= StErr;
                     error_q <= 1'b1;
                     busy_q  <= 1'b0;
                     bit_q   <= 5'd0;
                     frame_q <= 5'd0;
                     timer_q <= 8'd0;
                  end else begin
                     timer_q <= timer_q + 8'd1;
                  end
               end

               StTurna: begin
                  if (timer_q == TurnLast) begin
                     state_q <= StUp;
                     sen_n_q <= 1'b0;
                     bit_q   <= 5'd0;
                     frame_q <= 5'd0;
                     timer_q <= 8'd0;
                  end else begin
                     timer_q <= timer_q + 8'd1;
                  end
               end

               StUp: begin
                  if (bit_q == UpLastBit) begin
                     bit_q   <= 5'd0;
                     sen_n_q <= 1'b1;
                     timer_q <= 8'd0;
                     if (frame_q == UpLastFrame) begin
                        state_q <= StFin;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= StUgap;
                     end
                  end else begin
                     bit_q <= bit_q + 5'd1;
                  end
               end

               StUgap: begin
                  if (timer_q == UpGapLast) begin
                     state_q <= StUp;
                     sen_n_q <= 1'b0;
                     frame_q <= frame_q + 5'd1;
                     timer_q <= 8'd0;
                  end else begin
                     timer_q <= timer_q + 8'd1;
                  end
               end

               StFin: begin
                  state_q  <= StIdle;
                  updown_q <= 1'b0;
                  sen_n_q  <= 1'b1;
                  bit_q    <= 5'd0;
                  frame_q  <= 5'd0;
                  timer_q  <= 8'd0;
                  busy_q   <= 1'b0;
               end

               default: begin
                  state_q  <= StIdle;
                  updown_q <= 1'b0;
                  sen_n_q  <= 1'b1;
                  bit_q    <= 5'd0;
                  frame_q  <= 5'd0;
                  timer_q  <= 8'd0;
                  busy_q   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign updown_o    = updown_q;
   assign sen_n_o     = sen_n_q;
   assign bit_cnt_o   = bit_q;
   assign frame_cnt_o = frame_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign error_o     = error_q;

endmodule

// File: tb/tb_serial_link_sched.sv
// Scoreboard bench for serial_link_sched: stimulus queues per-cycle expected outputs, a negedge
// monitor pops and compares them against the DUT.
module tb_serial_link_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       rx_done = 1'b0;
   logic       updown;
   logic       sen_n;
   logic [4:0] bit_cnt;
   logic [4:0] frame_cnt;
   logic       busy;
   logic       done;
   logic       error;

   serial_link_sched dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start),
      .abort_i     (abort),
      .rx_done_i   (rx_done),
      .updown_o    (updown),
      .sen_n_o     (sen_n),
      .bit_cnt_o   (bit_cnt),
      .frame_cnt_o (frame_cnt),
      .busy_o      (busy),
      .done_o      (done),
      .error_o     (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // -1 in a field means "don't care".
   typedef struct packed {
      logic [63:0] tag;
      int cyc;
      int ud;
      int sn;
      int bc;
      int fc;
      int bz;
      int dn;
      int er;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void push(input logic [63:0] tag, input int c, input int ud, input int sn,
                                input int bc, input int fc, input int bz, input int dn,
                                input int er);
      exp_t e;
      e.tag = tag; e.cyc = c; e.ud = ud; e.sn = sn; e.bc = bc;
      e.fc = fc; e.bz = bz; e.dn = dn; e.er = er;
      q.push_back(e);
   endfunction

   function automatic bit m(input int e, input int a);
      return (e < 0) || (e == a);
   endfunction

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (e.cyc < cyc) begin
            errors++;
            $display("FAIL %s: check for cycle %0d missed at cycle %0d", e.tag, e.cyc, cyc);
         end else if (!(m(e.ud, int'(updown)) && m(e.sn, int'(sen_n)) && m(e.bc, int'(bit_cnt))
                     && m(e.fc, int'(frame_cnt)) && m(e.bz, int'(busy)) && m(e.dn, int'(done))
                     && m(e.er, int'(error)))) begin
            errors++;
            $display({"FAIL %s @%0d: got ud=%0d sn=%0d bit=%0d fr=%0d busy=%0d done=%0d err=%0d,",
                      " want ud=%0d sn=%0d bit=%0d fr=%0d busy=%0d done=%0d err=%0d"},
                     e.tag, cyc, updown, sen_n, bit_cnt, frame_cnt, busy, done, error,
                     e.ud, e.sn, e.bc, e.fc, e.bz, e.dn, e.er);
         end
      end
   end

   // Default timing: 8 frames of 21 bits + 1 gap = 175 down cycles; 18 x 13 + 1 gap = 251 up.
   function automatic void push_down(input int t0, input int kmax);
      for (int k = 1; k <= kmax; k++) begin
         int p, f;
         p = (k - 1) % 22;
         f = (k - 1) / 22;
         if (p < 21) push("down", t0 + k, 0, 0, p, f, 1, 0, 0);
         else        push("dgap", t0 + k, 0, 1, 0, f, 1, 0, 0);
      end
   endfunction

   function automatic void push_wait(input int t0, input int n);
      for (int i = 0; i < n; i++) push("wait", t0 + 176 + i, 0, 1, 0, -1, 1, 0, 0);
   endfunction

   function automatic void push_up(input int u, input int jmax);
      for (int j = 0; j < jmax; j++) begin
         int p, f;
         p = j % 14;
         f = j / 14;
         if (p < 13) push("up", u + j, 1, 0, p, f, 1, 0, 0);
         else        push("ugap", u + j, 1, 1, 0, f, 1, 0, 0);
      end
   endfunction

   // w = WAIT_ACK cycle index on which rx_done is seen.
   function automatic void push_txn(input int t0, input int w);
      int u;
      u = t0 + 179 + w;
      push_down(t0, 175);
      push_wait(t0, w + 1);
      push("turn", t0 + 177 + w, 1, 1, 0, -1, 1, 0, 0);
      push("turn", t0 + 178 + w, 1, 1, 0, -1, 1, 0, 0);
      push_up(u, 251);
      push("fin", u + 251, 1, 1, -1, -1, 1, 1, 0);
      push("idle", u + 252, 0, 1, 0, 0, 0, 0, 0);
   endfunction

   task automatic step_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      push("rst", 2, 0, 1, 0, 0, 0, 0, 0);
      push("rst", 3, 0, 1, 0, 0, 0, 0, 0);
      push("rst_idle", 6, 0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      step_to(4);
      rst = 1'b0;
      step_to(7);

      // Full transaction with rx_done held high; start pulses during UP are ignored.
      t0 = cyc;
      rx_done = 1'b1;
      push_txn(t0, 0);
      pulse_start();
      step_to(t0 + 200); pulse_start();
      step_to(t0 + 250); pulse_start();
      step_to(t0 + 300); pulse_start();
      step_to(t0 + 432);
      rx_done = 1'b0;

      // rx_done pulse on the last WAIT_ACK timer cycle still turns the line around.
      step_to(cyc + 2);
      t0 = cyc;
      push_txn(t0, 63);
      pulse_start();
      step_to(t0 + 239);
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      step_to(t0 + 496);

      // rx_done only during DOWN: timeout to ERR, restart from ERR, abort mid-frame.
      t0 = cyc;
      push_down(t0, 175);
      push_wait(t0, 64);
      for (int i = 240; i <= 244; i++) push("err", t0 + i, 0, 1, -1, -1, 0, 0, 1);
      push_down(t0 + 244, 77);
      push("abort_idle", t0 + 322, 0, 1, 0, 0, 0, 0, 0);
      push("abort_hold", t0 + 323, 0, 1, 0, 0, 0, 0, 0);
      pulse_start();
      step_to(t0 + 50);
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      step_to(t0 + 244);
      pulse_start();
      step_to(t0 + 321);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      step_to(t0 + 325);

      // Abort from ERR keeps error; abort beats start; then start clears error.
      t0 = cyc;
      push_down(t0, 175);
      push_wait(t0, 64);
      push("err", t0 + 240, 0, 1, -1, -1, 0, 0, 1);
      push("err", t0 + 241, 0, 1, -1, -1, 0, 0, 1);
      push("abort_err", t0 + 242, 0, 1, 0, 0, 0, 0, 1);
      push("abort_start", t0 + 243, 0, 1, 0, 0, 0, 0, 1);
      push("restart", t0 + 244, 0, 0, 0, 0, 1, 0, 0);
      push("restart", t0 + 245, 0, 0, 1, 0, 1, 0, 0);
      push("abort_idle", t0 + 247, 0, 1, 0, 0, 0, 0, 0);
      pulse_start();
      step_to(t0 + 241);
      abort = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
      start = 1'b0;
      step_to(t0 + 246);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      step_to(t0 + 249);

      // Asynchronous reset between edges in the middle of UP.
      t0 = cyc;
      rx_done = 1'b1;
      push_down(t0, 175);
      push_wait(t0, 1);
      push("turn", t0 + 177, 1, 1, 0, -1, 1, 0, 0);
      push("turn", t0 + 178, 1, 1, 0, -1, 1, 0, 0);
      push_up(t0 + 179, 71);
      push("async_rst", t0 + 250, 0, 1, 0, 0, 0, 0, 0);
      push("rst_hold", t0 + 251, 0, 1, 0, 0, 0, 0, 0);
      push_down(t0 + 253, 30);
      push("abort_idle", t0 + 284, 0, 1, 0, 0, 0, 0, 0);
      pulse_start();
      step_to(t0 + 249);
      @(posedge clk);
      #1 rst = 1'b1;
      step_to(t0 + 251);
      rst = 1'b0;
      rx_done = 1'b0;
      step_to(t0 + 253);
      pulse_start();
      step_to(t0 + 283);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;

      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         $display("FAIL drain: %0d expected entries never checked", q.size());
         checks += q.size();
         errors += q.size();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
